// File: rtl/eu_ybuf_arbiter_pkg.sv
// eu_ybuf_arbiter_pkg: shared data types for the exec-unit ybuf arbiter and its result queue.
package eu_ybuf_arbiter_pkg;
  typedef logic [7:0] type_alu_local_addr;
  typedef logic [31:0] type_exec_unit_data;
  typedef enum logic {YBUF_OP0 = 1'b0, YBUF_OP1 = 1'b1} type_ybuf_port_sel;
  typedef struct packed {
    type_alu_local_addr addr;
    type_exec_unit_data data;
  } type_res_entry;
endpackage

// File: rtl/eu_ybuf_arbiter_pick2.sv
// eu_rr_pick2: rotated priority encoder returning the first two requesters at or after ptr_i.
module eu_rr_pick2 #(
  parameter int N = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  win0_o,
  output logic [N-1:0]  win1_o,
  output logic          valid0_o,
  output logic          valid1_o,
  output logic [IW-1:0] idx0_o,
  output logic [IW-1:0] idx1_o
);
  logic [IW-1:0] j;
  always_comb begin
    valid0_o = 1'b0;
    valid1_o = 1'b0;
    idx0_o = '0;
    idx1_o = '0;
    j = '0;
    for (int k = 0; k < N; k++) begin
      j = IW'((int'(ptr_i) + k) % N);
      if (req_i[j] && !valid0_o) begin
        valid0_o = 1'b1;
        idx0_o = j;
      end else if (req_i[j] && !valid1_o) begin
        valid1_o = 1'b1;
        idx1_o = j;
      end
    end
  end
  assign win0_o = valid0_o ? N'(1) << idx0_o : '0;
  assign win1_o = valid1_o ? N'(1) << idx1_o : '0;
endmodule

// File: rtl/eu_ybuf_arbiter.sv
// eu_ybuf_arbiter: round-robin sharing of the ybuf op0/op1 read ports plus an
// in-order retrying result queue feeding the ybuf store port.
module eu_ybuf_arbiter
  import eu_ybuf_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int RES_Q_DEPTH = 4,
  parameter int RES_STALL_MAX = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req_valid_i,
  input  type_alu_local_addr req_addr_i [NUM_REQ],
  output logic [NUM_REQ-1:0] req_grant_o,
  output logic [NUM_REQ-1:0] rsp_valid_o,
  output logic [NUM_REQ-1:0] rsp_hit_o,
  output type_exec_unit_data rsp_data_o [NUM_REQ],
  input  logic               res_valid_i,
  input  type_alu_local_addr res_addr_i,
  input  type_exec_unit_data res_data_i,
  output logic               res_ready_o,
  output logic               res_stall_o,
  output type_alu_local_addr ybuf_op0_addr_o,
  output logic               ybuf_op0_valid_o,
  output type_alu_local_addr ybuf_op1_addr_o,
  output logic               ybuf_op1_valid_o,
  input  type_exec_unit_data ybuf_op0_data_i,
  input  logic               ybuf_op0_success_i,
  input  type_exec_unit_data ybuf_op1_data_i,
  input  logic               ybuf_op1_success_i,
  output type_alu_local_addr ybuf_result_addr_o,
  output type_exec_unit_data ybuf_result_data_o,
  output logic               ybuf_result_valid_o,
  input  logic               ybuf_result_success_i
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int AW = $clog2(RES_Q_DEPTH);
  localparam int CW = $clog2(RES_STALL_MAX + 1);
  logic [NUM_REQ-1:0] eligible, win0, win1, granted_q, granted_d;
  logic v0, v1;
  logic [IW-1:0] idx0, idx1, last, rr_ptr_q, rr_ptr_d;
  type_ybuf_port_sel sel_q [NUM_REQ];
  type_ybuf_port_sel sel_d [NUM_REQ];
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  type_res_entry mem_q [RES_Q_DEPTH];
  type_res_entry mem_d [RES_Q_DEPTH];
  type_res_entry head;
  logic [CW-1:0] cnt_q, cnt_d;
  logic stall_q, stall_d, empty, full, push, pop;
  assign eligible = req_valid_i & ~granted_q;
  eu_rr_pick2 #(.N(NUM_REQ)) u_pick (
    .req_i(eligible), .ptr_i(rr_ptr_q),
    .win0_o(win0), .win1_o(win1),
    .valid0_o(v0), .valid1_o(v1),
    .idx0_o(idx0), .idx1_o(idx1)
  );
  assign req_grant_o = win0 | win1;
  assign ybuf_op0_valid_o = v0;
  assign ybuf_op1_valid_o = v1;
  assign ybuf_op0_addr_o = v0 ? req_addr_i[idx0] : '0;
  assign ybuf_op1_addr_o = v1 ? req_addr_i[idx1] : '0;
  assign rsp_valid_o = granted_q;
  always_comb begin
    last = v1 ? idx1 : idx0;
    rr_ptr_d = !v0 ? rr_ptr_q : (int'(last) == NUM_REQ - 1) ? '0 : last + 1'b1;
    granted_d = win0 | win1;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_d[i] = win1[i] ? YBUF_OP1 : YBUF_OP0;
      rsp_hit_o[i] = granted_q[i] & ((sel_q[i] == YBUF_OP1) ? ybuf_op1_success_i : ybuf_op0_success_i);
      rsp_data_o[i] = !granted_q[i] ? '0 : (sel_q[i] == YBUF_OP1) ? ybuf_op1_data_i : ybuf_op0_data_i;
    end
  end
  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty = wr_q == rd_q;
  assign full = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign push = res_valid_i & ~full;
  assign pop = ybuf_result_success_i & ~empty;
  assign head = mem_q[rd_q[AW-1:0]];
  assign res_ready_o = ~full;
  assign res_stall_o = stall_q;
  assign ybuf_result_valid_o = ~empty;
  assign ybuf_result_addr_o = empty ? '0 : head.addr;
  assign ybuf_result_data_o = empty ? '0 : head.data;
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_q[AW-1:0]] = {res_addr_i, res_data_i};
    wr_d = wr_q + (AW + 1)'(push);
    rd_d = rd_q + (AW + 1)'(pop);
    cnt_d = (pop || empty) ? '0 : (int'(cnt_q) == RES_STALL_MAX) ? cnt_q : cnt_q + 1'b1;
    stall_d = int'(cnt_d) == RES_STALL_MAX;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      granted_q <= '0;
      sel_q <= '{default: YBUF_OP0};
      rr_ptr_q <= '0;
      wr_q <= '0;
      rd_q <= '0;
      mem_q <= '{default: '0};
      cnt_q <= '0;
      stall_q <= 1'b0;
    end else begin
      granted_q <= granted_d;
      sel_q <= sel_d;
      rr_ptr_q <= rr_ptr_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      mem_q <= mem_d;
      cnt_q <= cnt_d;
      stall_q <= stall_d;
    end
  end
endmodule

// File: tb/tb_eu_ybuf_arbiter.sv
// tb_eu_ybuf_arbiter: directed scenarios plus a randomized run against a queue-based reference model.
module tb_eu_ybuf_arbiter;
  import eu_ybuf_arbiter_pkg::*;
  localparam int N = 4;
  localparam int D = 4;
  localparam int SMAX = 8;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [N-1:0] req_valid_i, req_grant_o, rsp_valid_o, rsp_hit_o;
  type_alu_local_addr req_addr_i [N];
  type_exec_unit_data rsp_data_o [N];
  logic res_valid_i, res_ready_o, res_stall_o;
  type_alu_local_addr res_addr_i, ybuf_op0_addr_o, ybuf_op1_addr_o, ybuf_result_addr_o;
  type_exec_unit_data res_data_i, ybuf_op0_data_i, ybuf_op1_data_i, ybuf_result_data_o;
  logic ybuf_op0_valid_o, ybuf_op1_valid_o, ybuf_op0_success_i, ybuf_op1_success_i;
  logic ybuf_result_valid_o, ybuf_result_success_i;
  int tests = 0;
  int failed = 0;
  always #5 clk = ~clk;
  eu_ybuf_arbiter #(.NUM_REQ(N), .RES_Q_DEPTH(D), .RES_STALL_MAX(SMAX)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid_i(req_valid_i), .req_addr_i(req_addr_i), .req_grant_o(req_grant_o),
    .rsp_valid_o(rsp_valid_o), .rsp_hit_o(rsp_hit_o), .rsp_data_o(rsp_data_o),
    .res_valid_i(res_valid_i), .res_addr_i(res_addr_i), .res_data_i(res_data_i),
    .res_ready_o(res_ready_o), .res_stall_o(res_stall_o),
    .ybuf_op0_addr_o(ybuf_op0_addr_o), .ybuf_op0_valid_o(ybuf_op0_valid_o),
    .ybuf_op1_addr_o(ybuf_op1_addr_o), .ybuf_op1_valid_o(ybuf_op1_valid_o),
    .ybuf_op0_data_i(ybuf_op0_data_i), .ybuf_op0_success_i(ybuf_op0_success_i),
    .ybuf_op1_data_i(ybuf_op1_data_i), .ybuf_op1_success_i(ybuf_op1_success_i),
    .ybuf_result_addr_o(ybuf_result_addr_o), .ybuf_result_data_o(ybuf_result_data_o),
    .ybuf_result_valid_o(ybuf_result_valid_o), .ybuf_result_success_i(ybuf_result_success_i)
  );
  task automatic drive_idle();
    req_valid_i = '0;
    foreach (req_addr_i[i]) req_addr_i[i] = '0;
    res_valid_i = 1'b0;
    res_addr_i = '0;
    res_data_i = '0;
    ybuf_op0_data_i = '0;
    ybuf_op1_data_i = '0;
    ybuf_op0_success_i = 1'b0;
    ybuf_op1_success_i = 1'b0;
    ybuf_result_success_i = 1'b0;
  endtask
  task automatic do_reset();
    drive_idle();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    logic [9:0] flags;
    flags = {req_grant_o[1:0], rsp_valid_o[1:0], rsp_hit_o[1:0], ybuf_op0_valid_o, ybuf_op1_valid_o, ybuf_result_valid_o, res_stall_o};
    tests++;
    if ({req_grant_o, rsp_valid_o, rsp_hit_o, ybuf_op0_valid_o, ybuf_op1_valid_o, ybuf_result_valid_o, res_stall_o} !== '0) begin
      failed++;
      $display("FAIL reset_outputs got=%b grant=%b rspv=%b exp=all zero", flags, req_grant_o, rsp_valid_o);
    end
    foreach (rsp_data_o[i]) begin
      tests++;
      if (rsp_data_o[i] !== '0) begin
        failed++;
        $display("FAIL reset_rsp_data[%0d] got=%h exp=0", i, rsp_data_o[i]);
      end
    end
  endtask
  task automatic test_single_read();
    do_reset();
    req_valid_i = 4'b0100;
    req_addr_i[2] = 8'h03;
    @(negedge clk);
    tests++;
    if ({req_grant_o, ybuf_op0_valid_o, ybuf_op0_addr_o, ybuf_op1_valid_o} !== {4'b0100, 1'b1, 8'h03, 1'b0}) begin
      failed++;
      $display("FAIL single_grant got grant=%b op0v=%b op0a=%h op1v=%b exp 0100/1/03/0", req_grant_o, ybuf_op0_valid_o, ybuf_op0_addr_o, ybuf_op1_valid_o);
    end
    next_cycle();
    req_valid_i = '0;
    ybuf_op0_data_i = 32'h0000_00AB;
    ybuf_op0_success_i = 1'b1;
    @(negedge clk);
    tests++;
    if ({rsp_valid_o, rsp_hit_o, rsp_data_o[2]} !== {4'b0100, 4'b0100, 32'h0000_00AB}) begin
      failed++;
      $display("FAIL single_rsp got v=%b hit=%b data=%h exp 0100/0100/000000ab", rsp_valid_o, rsp_hit_o, rsp_data_o[2]);
    end
    next_cycle();
    drive_idle();
  endtask
  task automatic test_rr_all();
    logic [N-1:0] exp_g [3];
    exp_g = '{4'b0011, 4'b1100, 4'b0011};
    do_reset();
    req_valid_i = '1;
    foreach (req_addr_i[i]) req_addr_i[i] = type_alu_local_addr'(32'h10 + i);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      tests++;
      if ({req_grant_o, ybuf_op0_addr_o, ybuf_op1_addr_o} !==
          {exp_g[c], type_alu_local_addr'(c == 1 ? 8'h12 : 8'h10), type_alu_local_addr'(c == 1 ? 8'h13 : 8'h11)}) begin
        failed++;
        $display("FAIL rr_all c=%0d got grant=%b a0=%h a1=%h exp grant=%b", c, req_grant_o, ybuf_op0_addr_o, ybuf_op1_addr_o, exp_g[c]);
      end
      next_cycle();
    end
    drive_idle();
  endtask
  task automatic test_miss_remask();
    do_reset();
    req_valid_i = 4'b0011;
    req_addr_i[0] = 8'h40;
    req_addr_i[1] = 8'h41;
    @(negedge clk);
    tests++;
    if ({req_grant_o, ybuf_op1_valid_o, ybuf_op1_addr_o} !== {4'b0011, 1'b1, 8'h41}) begin
      failed++;
      $display("FAIL miss_first got grant=%b op1v=%b op1a=%h exp 0011/1/41", req_grant_o, ybuf_op1_valid_o, ybuf_op1_addr_o);
    end
    next_cycle();
    ybuf_op0_success_i = 1'b1;
    ybuf_op0_data_i = 32'h1111_0000;
    ybuf_op1_success_i = 1'b0;
    ybuf_op1_data_i = 32'h2222_0000;
    @(negedge clk);
    tests++;
    if ({rsp_valid_o, rsp_hit_o, rsp_data_o[1], req_grant_o} !== {4'b0011, 4'b0001, 32'h2222_0000, 4'b0000}) begin
      failed++;
      $display("FAIL miss_rsp got v=%b hit=%b d1=%h grant=%b exp 0011/0001/22220000/0000", rsp_valid_o, rsp_hit_o, rsp_data_o[1], req_grant_o);
    end
    next_cycle();
    ybuf_op0_success_i = 1'b0;
    @(negedge clk);
    tests++;
    if ({req_grant_o, ybuf_op1_valid_o, ybuf_op1_addr_o, rsp_valid_o} !== {4'b0011, 1'b1, 8'h41, 4'b0000}) begin
      failed++;
      $display("FAIL miss_regrant got grant=%b op1v=%b op1a=%h rspv=%b exp 0011/1/41/0000", req_grant_o, ybuf_op1_valid_o, ybuf_op1_addr_o, rsp_valid_o);
    end
    next_cycle();
    drive_idle();
  endtask
  task automatic test_queue_fill();
    do_reset();
    for (int i = 0; i < D; i++) begin
      res_valid_i = 1'b1;
      res_addr_i = type_alu_local_addr'(32'h20 + i);
      res_data_i = 32'hC0DE_0000 + i;
      @(negedge clk);
      tests++;
      if (res_ready_o !== 1'b1) begin
        failed++;
        $display("FAIL qfill_ready push=%0d got=%b exp=1", i, res_ready_o);
      end
      next_cycle();
    end
    res_addr_i = 8'h99;
    res_data_i = '1;
    @(negedge clk);
    tests++;
    if ({res_ready_o, ybuf_result_valid_o} !== 2'b01) begin
      failed++;
      $display("FAIL qfill_full got ready=%b valid=%b exp ready=0 valid=1", res_ready_o, ybuf_result_valid_o);
    end
    next_cycle();
    ybuf_result_success_i = 1'b1;
    for (int i = 0; i < D; i++) begin
      @(negedge clk);
      tests++;
      if ({ybuf_result_valid_o, ybuf_result_addr_o, ybuf_result_data_o} !==
          {1'b1, type_alu_local_addr'(32'h20 + i), 32'hC0DE_0000 + i}) begin
        failed++;
        $display("FAIL qfill_pop%0d got v=%b a=%h d=%h exp a=%h", i, ybuf_result_valid_o, ybuf_result_addr_o, ybuf_result_data_o, 32'h20 + i);
      end
      if (i == 0) begin
        tests++;
        if (res_ready_o !== 1'b0) begin
          failed++;
          $display("FAIL qfill_nobypass got ready=%b exp=0", res_ready_o);
        end
      end
      next_cycle();
      res_valid_i = 1'b0;
    end
    @(negedge clk);
    tests++;
    if ({ybuf_result_valid_o, res_ready_o} !== 2'b01) begin
      failed++;
      $display("FAIL qfill_empty got valid=%b ready=%b exp valid=0 ready=1", ybuf_result_valid_o, res_ready_o);
    end
    next_cycle();
    drive_idle();
  endtask
  task automatic test_stall();
    do_reset();
    res_valid_i = 1'b1;
    res_addr_i = 8'h55;
    res_data_i = 32'h5555_5555;
    next_cycle();
    res_valid_i = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      if (k == 10) ybuf_result_success_i = 1'b1;
      @(negedge clk);
      tests++;
      if (res_stall_o !== 1'(k >= 9)) begin
        failed++;
        $display("FAIL stall cycle=%0d got=%b exp=%b", k, res_stall_o, k >= 9);
      end
      next_cycle();
    end
    ybuf_result_success_i = 1'b0;
    @(negedge clk);
    tests++;
    if ({res_stall_o, ybuf_result_valid_o} !== 2'b00) begin
      failed++;
      $display("FAIL stall_clear got stall=%b valid=%b exp 0/0", res_stall_o, ybuf_result_valid_o);
    end
    next_cycle();
  endtask
  task automatic test_random();
    logic [N-1:0] m_prev = '0;
    logic m_port [N] = '{default: 1'b0};
    int m_ptr = 0;
    int run = 0;
    logic m_stall = 1'b0;
    type_res_entry q [$];
    int win [$];
    logic [N-1:0] exp_g;
    logic pop;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      req_valid_i = N'($urandom);
      foreach (req_addr_i[i]) req_addr_i[i] = type_alu_local_addr'($urandom);
      res_valid_i = 1'($urandom_range(0, 1));
      res_addr_i = type_alu_local_addr'($urandom);
      res_data_i = $urandom;
      ybuf_result_success_i = (c < 200) ? ($urandom_range(0, 3) == 0) : 1'($urandom_range(0, 1));
      ybuf_op0_data_i = $urandom;
      ybuf_op1_data_i = $urandom;
      ybuf_op0_success_i = 1'($urandom_range(0, 1));
      ybuf_op1_success_i = 1'($urandom_range(0, 1));
      win.delete();
      for (int k = 0; k < N; k++)
        if (req_valid_i[(m_ptr + k) % N] && !m_prev[(m_ptr + k) % N] && win.size() < 2) win.push_back((m_ptr + k) % N);
      exp_g = '0;
      foreach (win[w]) exp_g[win[w]] = 1'b1;
      @(negedge clk);
      tests++;
      if (req_grant_o !== exp_g) begin
        failed++;
        $display("FAIL rnd_grant c=%0d got=%b exp=%b", c, req_grant_o, exp_g);
      end
      tests++;
      if (ybuf_op0_valid_o !== (win.size() > 0) || ybuf_op1_valid_o !== (win.size() > 1) ||
          (win.size() > 0 && ybuf_op0_addr_o !== req_addr_i[win[0]]) ||
          (win.size() > 1 && ybuf_op1_addr_o !== req_addr_i[win[1]])) begin
        failed++;
        $display("FAIL rnd_ports c=%0d got v0=%b a0=%h v1=%b a1=%h exp wins=%0d", c, ybuf_op0_valid_o, ybuf_op0_addr_o, ybuf_op1_valid_o, ybuf_op1_addr_o, win.size());
      end
      for (int i = 0; i < N; i++) begin
        tests++;
        if (rsp_valid_o[i] !== m_prev[i] ||
            rsp_hit_o[i] !== (m_prev[i] & (m_port[i] ? ybuf_op1_success_i : ybuf_op0_success_i)) ||
            (m_prev[i] && rsp_data_o[i] !== (m_port[i] ? ybuf_op1_data_i : ybuf_op0_data_i))) begin
          failed++;
          $display("FAIL rnd_rsp c=%0d client=%0d got v=%b hit=%b d=%h exp v=%b port=%b", c, i, rsp_valid_o[i], rsp_hit_o[i], rsp_data_o[i], m_prev[i], m_port[i]);
        end
      end
      tests++;
      if (res_ready_o !== (q.size() < D) || ybuf_result_valid_o !== (q.size() > 0) ||
          (q.size() > 0 && {ybuf_result_addr_o, ybuf_result_data_o} !== q[0]) || res_stall_o !== m_stall) begin
        failed++;
        $display("FAIL rnd_queue c=%0d got rdy=%b v=%b a=%h stall=%b exp size=%0d stall=%b", c, res_ready_o, ybuf_result_valid_o, ybuf_result_addr_o, res_stall_o, q.size(), m_stall);
      end
      pop = ybuf_result_success_i && q.size() > 0;
      run = (q.size() > 0 && !ybuf_result_success_i) ? run + 1 : 0;
      m_stall = run >= SMAX;
      if (pop) void'(q.pop_front());
      if (res_valid_i && q.size() + int'(pop) < D) q.push_back({res_addr_i, res_data_i});
      m_prev = exp_g;
      foreach (win[w]) m_port[win[w]] = (w == 1);
      if (win.size() > 0) m_ptr = (win[win.size() - 1] + 1) % N;
      next_cycle();
    end
    drive_idle();
  endtask
  task automatic test_reset_inflight();
    do_reset();
    res_valid_i = 1'b1;
    res_addr_i = 8'h01;
    next_cycle();
    res_addr_i = 8'h02;
    next_cycle();
    res_valid_i = 1'b0;
    req_valid_i = '1;
    next_cycle();
    req_valid_i = '0;
    ybuf_op0_success_i = 1'b1;
    ybuf_op1_success_i = 1'b1;
    ybuf_op0_data_i = 32'hDEAD_BEEF;
    ybuf_op1_data_i = 32'hFEED_F00D;
    @(negedge clk);
    tests++;
    if ({rsp_valid_o, ybuf_result_valid_o} !== {4'b0011, 1'b1}) begin
      failed++;
      $display("FAIL inflight_pre got rspv=%b qv=%b exp 0011/1", rsp_valid_o, ybuf_result_valid_o);
    end
    #1 reset_n = 1'b0;
    #1;
    tests++;
    if ({rsp_valid_o, rsp_hit_o, req_grant_o, ybuf_op0_valid_o, ybuf_op1_valid_o, ybuf_result_valid_o, res_stall_o} !== '0 ||
        rsp_data_o[0] !== '0 || rsp_data_o[1] !== '0) begin
      failed++;
      $display("FAIL inflight_reset got rspv=%b hit=%b qv=%b d0=%h exp all zero", rsp_valid_o, rsp_hit_o, ybuf_result_valid_o, rsp_data_o[0]);
    end
    next_cycle();
    reset_n = 1'b1;
    req_valid_i = '1;
    @(negedge clk);
    tests++;
    if ({req_grant_o, ybuf_result_valid_o, rsp_valid_o} !== {4'b0011, 1'b0, 4'b0000}) begin
      failed++;
      $display("FAIL inflight_after got grant=%b qv=%b rspv=%b exp 0011/0/0000", req_grant_o, ybuf_result_valid_o, rsp_valid_o);
    end
    next_cycle();
    drive_idle();
  endtask
  initial begin
    drive_idle();
    reset_n = 1'b0;
    #12;
    test_reset();
    test_single_read();
    test_rr_all();
    test_miss_remask();
    test_queue_fill();
    test_stall();
    test_random();
    test_reset_inflight();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
